frv_mdu_param: RTL

- Parametrised iterative multiply/divide unit for the frv execute stage; implements the RV M-extension ops MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM and REMU.
- Generalises the fixed-width MDU as follows:
  - XLEN-parametrised datapath.
  - Independent multiplier and divider unroll factors.
  - Explicit FSM with a one-cycle ready pulse.
  - Architectural divide-by-zero and signed-overflow fast paths.
- Sits beside the ALU; the pipeline stalls until ready.

---
 rtl/frv_mdu_param_if.sv | 55 +++++
 rtl/frv_mdu_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_mdu_param_if.sv
// ----------------------------------------------------------------------------
// frv_mdu_param_if
//   Request/response bundle between the execute stage and the iterative
//   multiply/divide unit.
//
//   Parameter:
//     XLEN       datapath width (32 or 64)
//
//   Signals (direction seen from the execute stage / master):
//     valid      out  op_* and rs1/rs2 valid; held stable until ready
//     flush      out  abandon any operation in flight
//     op_*       out  one-hot operation select (8 RV M-extension ops)
//     rs1        out  multiplicand / dividend
//     rs2        out  multiplier / divisor
//     ready      in   one-cycle result pulse
//     rd         in   result; meaningful while ready is high
//     busy       in   unit is not idle
//     g_clk_req  in   clock request (valid | flush | busy)
// ----------------------------------------------------------------------------
interface frv_mdu_param_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            flush;
    logic            op_mul;
    logic            op_mulh;
    logic            op_mulhu;
    logic            op_mulhsu;
    logic            op_div;
    logic            op_divu;
    logic            op_rem;
    logic            op_remu;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            ready;
    logic [XLEN-1:0] rd;
    logic            busy;
    logic            g_clk_req;

    modport master (
        output valid, flush,
        output op_mul, op_mulh, op_mulhu, op_mulhsu,
        output op_div, op_divu, op_rem, op_remu,
        output rs1, rs2,
        input  ready, rd, busy, g_clk_req
    );

    modport slave (
        input  valid, flush,
        input  op_mul, op_mulh, op_mulhu, op_mulhsu,
        input  op_div, op_divu, op_rem, op_remu,
        input  rs1, rs2,
        output ready, rd, busy, g_clk_req
    );
endinterface

// File: rtl/frv_mdu_param.sv
// ----------------------------------------------------------------------------
// frv_mdu_param
//   Parametrised iterative multiply/divide unit for the frv execute stage.
//   Implements MUL, MULH, MULHU, MULHSU, DIV, DIVU, REM and REMU. The
//   multiplier retires MUL_UNROLL rhs bits per cycle into a 2*XLEN
//   accumulator; the divider is a restoring divider retiring DIV_UNROLL
//   quotient bits per cycle, MSB first. Divide-by-zero and signed overflow
//   complete from DPREP without iterating.
//
//   Parameters:
//     XLEN        datapath width: 32 or 64
//     MUL_UNROLL  multiplier bits per cycle: 1/2/4/8, divides XLEN
//     DIV_UNROLL  quotient bits per cycle: 1/2/4, divides XLEN
//
//   Ports:
//     g_clk    in  clock, rising edge
//     g_reset  in  synchronous active-high reset
//     mdu      frv_mdu_param_if.slave (valid/flush/op_*/rs1/rs2 in,
//              ready/rd/busy/g_clk_req out)
//
//   Build option:
//     FRV_MDU_EARLY_OUT_EN  when defined, a multiply with a zero operand
//                           completes straight from IDLE and a divide/rem
//                           with a zero dividend (non-zero divisor)
//                           completes from DPREP, both with rd=0.
// ----------------------------------------------------------------------------
module frv_mdu_param #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 4,
    parameter int DIV_UNROLL = 1
) (
    input  logic           g_clk,
    input  logic           g_reset,
    frv_mdu_param_if.slave mdu
);
    localparam int CW        = $clog2(XLEN) + 1;
    localparam int MUL_STEPS = XLEN / MUL_UNROLL;
    localparam int DIV_STEPS = XLEN / DIV_UNROLL;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DPREP,
        S_DIV,
        S_DONE
    } state_e;

    // Operation attributes latched at accept time, plus divide sign state.
    typedef struct packed {
        logic is_div;      // result comes from the divider
        logic hi;          // mulh/mulhu/mulhsu: upper product half
        logic rhs_signed;  // mulh only: rhs MSB carries negative weight
        logic sel_rem;     // rem/remu: remainder rather than quotient
        logic div_signed;  // div/rem: operands are two's complement
        logic q_neg;       // negate quotient at the end
        logic r_neg;       // negate remainder at the end
        logic fast;        // result produced by a fast path, no correction
    } ctl_t;

    state_e            state_q, state_d;
    ctl_t              ctl_q, ctl_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;      // mul: product; div: {rem, quo}
    logic [2*XLEN-1:0] mcand_q, mcand_d;  // extended lhs, shifted left
    logic [XLEN-1:0]   opb_q, opb_d;      // mul: rhs (shifted right); div: divisor
    logic [XLEN-1:0]   rd_q, rd_d;

    // ------------------------------------------------------------------
    // Operation decode and DPREP conditions
    // ------------------------------------------------------------------
    logic any_mul, any_div, lhs_signed;
    logic div_by_zero, div_ovf, rs1_neg, rs2_neg;
    logic mul_zero, div_zero;
    logic [XLEN-1:0] abs1, abs2;

    assign any_mul    = mdu.op_mul | mdu.op_mulh | mdu.op_mulhu | mdu.op_mulhsu;
    assign any_div    = mdu.op_div | mdu.op_divu | mdu.op_rem | mdu.op_remu;
    assign lhs_signed = mdu.op_mulh | mdu.op_mulhsu;

    assign div_by_zero = (mdu.rs2 == '0);
    assign div_ovf     = ctl_q.div_signed
                       & (mdu.rs1 == {1'b1, {(XLEN-1){1'b0}}})
                       & (mdu.rs2 == '1);
    assign rs1_neg     = ctl_q.div_signed & mdu.rs1[XLEN-1];
    assign rs2_neg     = ctl_q.div_signed & mdu.rs2[XLEN-1];
    // The most negative value maps onto 2^(XLEN-1), which fits unsigned.
    assign abs1        = rs1_neg ? -mdu.rs1 : mdu.rs1;
    assign abs2        = rs2_neg ? -mdu.rs2 : mdu.rs2;

`ifdef FRV_MDU_EARLY_OUT_EN
    assign mul_zero = (mdu.rs1 == '0) | (mdu.rs2 == '0);
    assign div_zero = (mdu.rs1 == '0);
`else
    assign mul_zero = 1'b0;
    assign div_zero = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Multiply step: MUL_UNROLL partial products per cycle
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] mul_acc;

    always_comb begin
        mul_acc = acc_q;
        // NOTE: blocking assignments inside combinational logic let each
        // loop iteration see the previous iteration's sum within one cycle.
        for (int j = 0; j < MUL_UNROLL; j++) begin
            if (opb_q[j]) begin
                // Signed rhs: its MSB is worth -2^(XLEN-1), so the very last
                // partial product is subtracted.
                if (ctl_q.rhs_signed && (cnt_q == CW'(1)) && (j == MUL_UNROLL - 1))
                    mul_acc = mul_acc - (mcand_q << j);
                else
                    mul_acc = mul_acc + (mcand_q << j);
            end
        end
    end

    // ------------------------------------------------------------------
    // Divide step: DIV_UNROLL restoring iterations per cycle
    // ------------------------------------------------------------------
    logic [XLEN-1:0] div_rem, div_quo;
    logic [XLEN:0]   div_try;
    logic [XLEN+1:0] div_diff;

    always_comb begin
        div_rem  = acc_q[2*XLEN-1:XLEN];
        div_quo  = acc_q[XLEN-1:0];
        div_try  = '0;
        div_diff = '0;
        for (int j = 0; j < DIV_UNROLL; j++) begin
            // Partial remainder stays below the divisor, so the shifted trial
            // value needs XLEN+1 bits and the difference one more for borrow.
            div_try  = {div_rem, div_quo[XLEN-1]};
            div_diff = {1'b0, div_try} - {2'b0, opb_q};
            div_quo  = {div_quo[XLEN-2:0], ~div_diff[XLEN+1]};
            div_rem  = div_diff[XLEN+1] ? div_try[XLEN-1:0] : div_diff[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge g_clk) begin
        if (g_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (mdu.valid && any_mul)      state_d = mul_zero ? S_DONE : S_MUL;
                else if (mdu.valid && any_div) state_d = S_DPREP;
            end
            S_MUL:   if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DPREP: state_d = (div_by_zero || div_ovf || div_zero) ? S_DONE : S_DIV;
            S_DIV:   if (cnt_q == CW'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (mdu.flush) state_d = S_IDLE;
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    logic [XLEN-1:0] quo_fix, rem_fix, result;

    always_comb begin
        ctl_d   = ctl_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        opb_d   = opb_q;
        rd_d    = rd_q;
        unique case (state_q)
            S_IDLE: begin
                if (mdu.valid && (any_mul || any_div)) begin
                    ctl_d.is_div     = ~any_mul;
                    ctl_d.hi         = mdu.op_mulh | mdu.op_mulhu | mdu.op_mulhsu;
                    ctl_d.rhs_signed = mdu.op_mulh;
                    ctl_d.sel_rem    = mdu.op_rem | mdu.op_remu;
                    ctl_d.div_signed = mdu.op_div | mdu.op_rem;
                    ctl_d.q_neg      = 1'b0;
                    ctl_d.r_neg      = 1'b0;
                    ctl_d.fast       = any_mul & mul_zero;
                    acc_d            = '0;
                    if (any_mul) begin
                        mcand_d = {{XLEN{lhs_signed & mdu.rs1[XLEN-1]}}, mdu.rs1};
                        opb_d   = mdu.rs2;
                        cnt_d   = CW'(MUL_STEPS);
                    end
                end
            end
            S_MUL: begin
                acc_d   = mul_acc;
                mcand_d = mcand_q << MUL_UNROLL;
                opb_d   = opb_q >> MUL_UNROLL;
                cnt_d   = cnt_q - CW'(1);
            end
            S_DPREP: begin
                if (div_by_zero) begin
                    acc_d      = {mdu.rs1, {XLEN{1'b1}}};
                    ctl_d.fast = 1'b1;
                end else if (div_ovf) begin
                    acc_d      = {{XLEN{1'b0}}, mdu.rs1};
                    ctl_d.fast = 1'b1;
                end else if (div_zero) begin
                    acc_d      = '0;
                    ctl_d.fast = 1'b1;
                end else begin
                    acc_d       = {{XLEN{1'b0}}, abs1};
                    opb_d       = abs2;
                    ctl_d.q_neg = rs1_neg ^ rs2_neg;
                    ctl_d.r_neg = rs1_neg;
                    cnt_d       = CW'(DIV_STEPS);
                end
            end
            S_DIV: begin
                acc_d = {div_rem, div_quo};
                cnt_d = cnt_q - CW'(1);
            end
            S_DONE:  rd_d = result;
            default: ;
        endcase
        if (mdu.flush) cnt_d = '0;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            ctl_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            opb_q   <= '0;
            rd_q    <= '0;
        end else begin
            ctl_q   <= ctl_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            opb_q   <= opb_d;
            rd_q    <= rd_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    logic ready_o, busy_o;
    logic [XLEN-1:0] rd_o;

    always_comb begin
        quo_fix = (ctl_q.q_neg && !ctl_q.fast) ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
        rem_fix = (ctl_q.r_neg && !ctl_q.fast) ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (ctl_q.is_div) result = ctl_q.sel_rem ? rem_fix : quo_fix;
        else              result = ctl_q.hi ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        ready_o = (state_q == S_DONE);
        busy_o  = (state_q != S_IDLE);
        // rd shows the fresh result in DONE and holds it until the next DONE.
        rd_o    = ready_o ? result : rd_q;
    end

    assign mdu.ready     = ready_o;
    assign mdu.busy      = busy_o;
    assign mdu.rd        = rd_o;
    assign mdu.g_clk_req = mdu.valid | mdu.flush | busy_o;

endmodule
